// File: rtl/ma_sched_pkg.sv
// ============================================================================
// Module   : ma_sched_pkg
// Purpose  : Shared widths, types and the averaging helper for the
//            ma_channel_scheduler slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ma_sched_pkg;

   localparam int N      = 4;
   localparam int L      = 4;
   localparam int WLI    = 2;
   localparam int WLF    = 10;
   localparam int WOI    = 2;
   localparam int WOF    = 30;

   localparam int IN_W   = WLI + WLF;
   localparam int LOG2L  = $clog2(L);
   localparam int SUM_W  = IN_W + LOG2L;
   localparam int OUT_W  = WOI + WOF;
   localparam int CH_W   = $clog2(N);
   localparam int FILL_W = LOG2L + 1;

   typedef logic signed [IN_W-1:0]  sample_t;
   typedef logic signed [SUM_W-1:0] sum_t;
   typedef logic signed [OUT_W-1:0] out_t;
   typedef logic [CH_W-1:0]         chan_t;
   typedef logic [FILL_W-1:0]       fill_t;

   // Divide by L rounding toward zero: negative sums are biased by L-1
   // before the arithmetic shift so the shift does not round toward -inf.
   function automatic out_t avg_trunc(input sum_t s);
      sum_t biased;
      biased = s[SUM_W-1] ? s + sum_t'(L-1) : s;
      return out_t'(biased >>> LOG2L);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ma_channel_scheduler_arb.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : N-way round-robin arbiter with a registered priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import ma_sched_pkg::*;
(
   input  logic          CLK,
   input  logic          RST,
   input  logic [N-1:0]  req,
   input  logic          enable,
   input  logic          advance,
   output logic [N-1:0]  grant
);

   chan_t r_ptr;
   chan_t w_idx;
   logic  w_found;

   // Search starts at the pointer; N is a power of two so chan_t wraps.
   always_comb begin
      w_idx   = r_ptr;
      w_found = 1'b0;
      grant   = '0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && req[r_ptr + chan_t'(i)]) begin
            w_found = 1'b1;
            w_idx   = r_ptr + chan_t'(i);
         end
      end
      if (enable && w_found)
         grant[w_idx] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_ptr <= '0;
      else if (advance)
         r_ptr <= w_idx + chan_t'(1);
   end

endmodule

`default_nettype wire

// File: rtl/ma_channel_scheduler.sv
// ============================================================================
// Module   : ma_channel_scheduler
// Purpose  : One moving-average engine time-shared by N channels through a
//            round-robin arbiter. Optional macro MA_WARMUP_MASK_EN suppresses
//            results until a channel's window is full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ma_channel_scheduler
   import ma_sched_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic [N-1:0]        in_valid,
   input  logic [N*IN_W-1:0]   in_data,
   output logic [N-1:0]        in_ready,
   input  logic                clr_valid,
   input  logic [CH_W-1:0]     clr_chan,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH_W-1:0]     out_chan,
   output logic [OUT_W-1:0]    out_data,
   output logic [N-1:0]        chan_full
);

   sample_t r_win  [N][L];
   sum_t    r_sum  [N];
   fill_t   r_fill [N];

   logic         w_slot_free;
   logic         w_accept;
   logic         w_load;
   logic [N-1:0] w_clr_mask;
   logic [N-1:0] w_req;
   chan_t        w_sel;
   sample_t      w_sample;
   sum_t         w_sum_new;
   fill_t        w_fill_new;

   assign w_slot_free = !out_valid || out_ready;
   assign w_clr_mask  = clr_valid ? (N'(1) << clr_chan) : '0;
   assign w_req       = in_valid & ~w_clr_mask;
   assign w_accept    = |in_ready;

   rr_arbiter u_arb (
      .CLK     (CLK),
      .RST     (RST),
      .req     (w_req),
      .enable  (w_slot_free),
      .advance (w_accept),
      .grant   (in_ready)
   );

   always_comb begin
      w_sel = '0;
      for (int c = 0; c < N; c++)
         if (in_ready[c])
            w_sel = chan_t'(c);
   end

   assign w_sample   = in_data[w_sel*IN_W +: IN_W];
   assign w_sum_new  = r_sum[w_sel] - sum_t'(r_win[w_sel][L-1]) + sum_t'(w_sample);
   assign w_fill_new = (r_fill[w_sel] == fill_t'(L)) ? fill_t'(L) : r_fill[w_sel] + fill_t'(1);

`ifdef MA_WARMUP_MASK_EN
   assign w_load = w_accept && (w_fill_new == fill_t'(L));
`else
   assign w_load = w_accept;
`endif

   // A cleared channel is masked out of arbitration, so clear and accept
   // never target the same channel in one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int c = 0; c < N; c++) begin
            r_sum[c]  <= '0;
            r_fill[c] <= '0;
            for (int k = 0; k < L; k++)
               r_win[c][k] <= '0;
         end
      end else begin
         if (clr_valid) begin
            r_sum[clr_chan]  <= '0;
            r_fill[clr_chan] <= '0;
            for (int k = 0; k < L; k++)
               r_win[clr_chan][k] <= '0;
         end
         if (w_accept) begin
            r_sum[w_sel]    <= w_sum_new;
            r_fill[w_sel]   <= w_fill_new;
            r_win[w_sel][0] <= w_sample;
            for (int k = 1; k < L; k++)
               r_win[w_sel][k] <= r_win[w_sel][k-1];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid <= 1'b0;
         out_chan  <= '0;
         out_data  <= '0;
      end else if (w_load) begin
         out_valid <= 1'b1;
         out_chan  <= w_sel;
         out_data  <= avg_trunc(w_sum_new);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   for (genvar c = 0; c < N; c++) begin : g_full
      assign chan_full[c] = (r_fill[c] == fill_t'(L));
   end

endmodule

`default_nettype wire

// File: tb/tb_ma_channel_scheduler.sv
// ============================================================================
// Module   : tb_ma_channel_scheduler
// Purpose  : Directed self-checking bench for ma_channel_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ma_channel_scheduler;

   localparam int N = 4;

   logic          CLK;
   logic          RST;
   logic [N-1:0]  in_valid;
   logic [47:0]   in_data;
   logic [N-1:0]  in_ready;
   logic          clr_valid;
   logic [1:0]    clr_chan;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_chan;
   logic [31:0]   out_data;
   logic [N-1:0]  chan_full;

   int n_checks = 0;
   int n_fail   = 0;

   ma_channel_scheduler dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .clr_valid (clr_valid),
      .clr_chan  (clr_chan),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan),
      .out_data  (out_data),
      .chan_full (chan_full)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input logic [11:0] d0, input logic [11:0] d1,
                           input logic [11:0] d2, input logic [11:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   // Apply inputs shortly after an edge, check the grant before the next
   // edge, then step to just after that edge.
   task automatic drive(input logic [N-1:0] iv, input logic ordy,
                        input logic [N-1:0] exp_rdy, input string tag);
      in_valid  = iv;
      out_ready = ordy;
      #1;
      check({tag, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [1:0] ch,
                          input logic [31:0] d);
      check({tag, "_vld"}, 32'(out_valid), 32'(v));
      check({tag, "_ch"},  32'(out_chan),  32'(ch));
      check({tag, "_dat"}, out_data, d);
   endtask

   initial begin
      RST       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      clr_valid = 1'b0;
      clr_chan  = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk_out("reset", 1'b0, 2'd0, 32'h0);
      check("reset_full", 32'(chan_full), 32'h0);
      RST = 1'b0;

`ifndef MA_WARMUP_MASK_EN
      // Channel 0 alone, 1.0 repeatedly: the window fills up to 1.0
      set_data(12'h400, 12'h000, 12'h000, 12'h000);
      drive(4'b0001, 1'b1, 4'b0001, "c0_s1"); chk_out("c0_s1", 1'b1, 2'd0, 32'h100);
      drive(4'b0001, 1'b1, 4'b0001, "c0_s2"); chk_out("c0_s2", 1'b1, 2'd0, 32'h200);
      drive(4'b0001, 1'b1, 4'b0001, "c0_s3"); chk_out("c0_s3", 1'b1, 2'd0, 32'h300);
      check("c0_s3_full", 32'(chan_full), 32'h0);
      drive(4'b0001, 1'b1, 4'b0001, "c0_s4"); chk_out("c0_s4", 1'b1, 2'd0, 32'h400);
      check("c0_s4_full", 32'(chan_full), 32'h1);
      drive(4'b0001, 1'b1, 4'b0001, "c0_s5"); chk_out("c0_s5", 1'b1, 2'd0, 32'h400);

      // Channel 1 negative samples: -3/4 -> 0, -5/4 -> -1
      set_data(12'h400, 12'hFFD, 12'h000, 12'h000);
      drive(4'b0010, 1'b1, 4'b0010, "c1_m3"); chk_out("c1_m3", 1'b1, 2'd1, 32'h0);
      set_data(12'h400, 12'hFFE, 12'h000, 12'h000);
      drive(4'b0010, 1'b1, 4'b0010, "c1_m5"); chk_out("c1_m5", 1'b1, 2'd1, 32'hFFFF_FFFF);

      // All channels requesting; pointer sits at 2 after the last grant to 1
      set_data(12'h400, 12'h004, 12'h200, 12'h100);
      drive(4'b1111, 1'b1, 4'b0100, "rr_a"); chk_out("rr_a", 1'b1, 2'd2, 32'h80);
      drive(4'b1111, 1'b1, 4'b1000, "rr_b"); chk_out("rr_b", 1'b1, 2'd3, 32'h40);
      drive(4'b1111, 1'b1, 4'b0001, "rr_c"); chk_out("rr_c", 1'b1, 2'd0, 32'h400);
      drive(4'b1111, 1'b1, 4'b0010, "rr_d"); chk_out("rr_d", 1'b1, 2'd1, 32'h0);

      // Backpressure: output frozen, no grant, then grant in the drain cycle
      drive(4'b0100, 1'b0, 4'b0000, "bp_1"); chk_out("bp_1", 1'b1, 2'd1, 32'h0);
      drive(4'b0100, 1'b0, 4'b0000, "bp_2"); chk_out("bp_2", 1'b1, 2'd1, 32'h0);
      drive(4'b0100, 1'b0, 4'b0000, "bp_3"); chk_out("bp_3", 1'b1, 2'd1, 32'h0);
      drive(4'b0100, 1'b1, 4'b0100, "bp_go"); chk_out("bp_go", 1'b1, 2'd2, 32'h100);
      drive(4'b0000, 1'b1, 4'b0000, "drain");
      check("drain_vld", 32'(out_valid), 32'h0);

      // Fill channel 3 (0.25 each), then clear it while it requests
      drive(4'b1000, 1'b1, 4'b1000, "c3_f2"); chk_out("c3_f2", 1'b1, 2'd3, 32'h80);
      drive(4'b1000, 1'b1, 4'b1000, "c3_f3"); chk_out("c3_f3", 1'b1, 2'd3, 32'hC0);
      drive(4'b1000, 1'b1, 4'b1000, "c3_f4"); chk_out("c3_f4", 1'b1, 2'd3, 32'h100);
      check("c3_full", 32'(chan_full), 32'h9);
      clr_valid = 1'b1;
      clr_chan  = 2'd3;
      drive(4'b1000, 1'b1, 4'b0000, "clr");
      clr_valid = 1'b0;
      check("clr_full", 32'(chan_full), 32'h1);
      check("clr_vld", 32'(out_valid), 32'h0);
      set_data(12'h400, 12'h004, 12'h200, 12'h400);
      drive(4'b1000, 1'b1, 4'b1000, "c3_new"); chk_out("c3_new", 1'b1, 2'd3, 32'h100);

      // Asynchronous reset mid-cycle discards the held result
      RST = 1'b1;
      #1;
      chk_out("rst_mid", 1'b0, 2'd0, 32'h0);
      check("rst_mid_full", 32'(chan_full), 32'h0);
      in_valid = 4'b1111;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      drive(4'b1111, 1'b1, 4'b0001, "rst_ptr"); chk_out("rst_ptr", 1'b1, 2'd0, 32'h100);
`else
      // Warm-up masking: only the full-window average is presented
      set_data(12'h400, 12'h000, 12'h000, 12'h000);
      drive(4'b0001, 1'b1, 4'b0001, "wm_1"); check("wm_1_vld", 32'(out_valid), 32'h0);
      drive(4'b0001, 1'b1, 4'b0001, "wm_2"); check("wm_2_vld", 32'(out_valid), 32'h0);
      drive(4'b0001, 1'b1, 4'b0001, "wm_3"); check("wm_3_vld", 32'(out_valid), 32'h0);
      drive(4'b0001, 1'b1, 4'b0001, "wm_4"); chk_out("wm_4", 1'b1, 2'd0, 32'h400);
      check("wm_4_full", 32'(chan_full), 32'h1);
      RST = 1'b1;
      #1;
      chk_out("wm_rst", 1'b0, 2'd0, 32'h0);
      check("wm_rst_full", 32'(chan_full), 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ma_channel_scheduler.md
Name: ma_channel_scheduler

Overview:
Shares one moving-average engine (window length L, Q2.10 in, 32-bit out) between N sample requesters. It does the following:
- Picks one channel per cycle with a round-robin arbiter.
- Holds a private window, running sum and fill count for each channel.
- Produces one averaged result per accepted sample, tagged with its channel.
- Gives downstream backpressure control over the output.

It sits between the per-channel ADC/front-end sample streams and the downstream filter/decimator chain. It replaces N separate moving-average instances.

Parameters:
- N, 4, number of requesting channels (≥2, power of 2)
- L, 4, window length per channel (power of 2, ≥2)
- WLI, 2, input integer bits
- WLF, 10, input fraction bits
- WOI, 2, output integer bits
- WOF, 30, output fraction-field bits (output width WOI+WOF=32)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  N  per-channel sample valid
- in_data  in  N*(WLI+WLF)  packed samples; channel c occupies bits [c*12 +: 12], signed
- in_ready  out  N  one-hot grant; handshake when in_valid[c]&&in_ready[c]
- clr_valid  in  1  single-cycle channel-clear command
- clr_chan  in  log2(N)  channel to clear
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_chan  out  log2(N)  channel of result
- out_data  out  WOI+WOF  signed average
- chan_full  out  N  channel window holds L samples since reset/clear

Behaviour:
- Reset is asynchronous and active-high; CLK is the only clock. Reset sets:
  - all windows, sums and fill counts to 0
  - RR pointer to 0
  - out_valid=0, out_chan=0, out_data=0, chan_full=0
- in_ready is combinational from in_valid, the RR pointer, output state and clear.
- Requesters must not make in_valid depend on in_ready.
- A slot is free when !out_valid || out_ready. No grant is issued unless the slot is free.
- Arbitration: grant the first c with in_valid[c], searching pointer, pointer+1, … mod N.
  - After a handshake, pointer = granted+1 mod N.
  - With no handshake, the pointer holds.
  - At most one in_ready bit is high.
- Clear:
  - When clr_valid, channel clr_chan is excluded from arbitration that cycle.
  - At the edge, its window, sum and fill count go to 0 and chan_full[clr_chan] goes to 0.
  - A result for that channel already in the output register is unaffected.
  - Clear does not touch the RR pointer.
- Accept at edge k for channel c:
  - sum_new = sum[c] - window[c][L-1] + sample
  - window shifts by one: window[0]=sample, window[L-1] is dropped
  - fill = min(fill+1, L); chan_full[c]=1 when fill reaches L
  - The result includes the accepted sample.
  - out_data = sum_new / L, signed and truncated toward zero (e.g. -3/4=0, -5/4=-1), sign-extended to 32 bits.
  - The LSB weight equals the input LSB (2^-WLF).
  - out_valid=1 and out_chan=c after edge k. Latency is 1 cycle.
- Sum width: WLI+WLF+log2(L) bits. No overflow is possible.
- Output hold: while out_valid && !out_ready, out_data and out_chan are stable and in_ready=0.
- Back-to-back: with out_ready held at 1, one result per cycle.
- Simultaneous drain and accept: the output register reloads. out_valid stays 1.
- Drain with no accept: out_valid drops to 0.
- Reset mid-operation: everything clears immediately. The in-flight result is discarded.

Optional Feature:
MA_WARMUP_MASK_EN
- Defined: an accepted sample whose post-update fill < L updates state but does not load the output register (out_valid not set). Requesters must handle dropped early results; only full-window averages appear.
- Undefined: every accepted sample produces a result. Empty slots count as zero.

Decomposition:
- Package ma_sched_pkg holds:
  - WLI, WLF, WOI, WOF, L, N
  - derived widths: IN_W, SUM_W, OUT_W, CH_W
  - typedefs: sample_t, sum_t, out_t, chan_t
- Sub-module rr_arbiter: N-way round-robin with a registered pointer.
  - Inputs: req, enable, advance.
  - Output: one-hot grant.
- The per-channel storage and the average datapath stay in the top.

Test Plan:
- Ch0 only, out_ready=1, in_data=0x400 (1.0) four times → out_data 256, 512, 768, 1024 on consecutive cycles. Fifth 0x400 → 1024. chan_full[0] rises after the 4th accept.
- All four valid continuously, out_ready=1 → grants in order 0,1,2,3,0,…. Each channel's results are independent.
- Ch1 single sample -3 (0xFFD) → out_data 0. Then -2 → sum -5 → out_data -1 (truncation toward zero, sign-extended to 0xFFFFFFFF).
- out_ready=0 for 3 cycles with ch2 valid → in_ready=0 and output frozen. When out_ready returns, the next grant occurs in the same cycle as the drain.
- Fill ch3, then clr_valid with clr_chan=3 while in_valid[3]=1 → no grant to 3 that cycle; chan_full[3]=0. Next sample 0x400 → 256.
- With MA_WARMUP_MASK_EN, 4×0x400 on ch0 → only the 4th produces out_valid, with value 1024. Assert RST mid-stream → out_valid=0 immediately.
